// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, carry chaining and multi-cycle SHLN.
// Define ALU_MUL_EN to add cmd 10 as an iterative unsigned shift-add multiply.
module alu_seq #(
    parameter int W     = 8,
    parameter int CMD_W = 4,
    parameter int CNT_W = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] alu_cmd,
    input  logic [W-1:0]     inA,
    input  logic [W-1:0]     inB,
    input  logic             sc_i,
    input  logic             use_sc,
    output logic             out_valid,
    output logic [W-1:0]     rslt,
    output logic             sc_o,
    output logic             pari,
    output logic             zero,
    output logic             err
);
    localparam int CW = CNT_W + 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;
    logic [W-1:0] acc, s_r, b_r, w_r;
    logic [CW-1:0] cnt;
    logic [CNT_W-1:0] n;
    logic [W:0] sum, dif;
    logic accept, cin, last, shln, mul, multi, done, s_c, s_e, b_c, w_c;
`ifdef ALU_MUL_EN
    logic is_mul;
    logic [2*W-1:0] mcand, prod, prod_nxt;
`endif

    assign n      = inB[CNT_W-1:0];
    assign cin    = use_sc ? sc_o : sc_i;
    assign accept = in_valid & in_ready;
    assign last   = cnt == CW'(1);
    assign shln   = alu_cmd == CMD_W'(9) && n != '0;
`ifdef ALU_MUL_EN
    assign mul    = alu_cmd == CMD_W'(10);
`else
    assign mul    = 1'b0;
`endif
    assign multi  = accept & (shln | mul);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb
        state_nxt = state == IDLE ? (multi ? BUSY : IDLE) : (last ? IDLE : BUSY);

    // in IDLE in_ready is 1, so in_valid alone stands for accept here
    always_comb begin
        in_ready = state == IDLE;
        done     = state == BUSY ? last : in_valid & ~(shln | mul);
    end

    always_comb begin
        sum = {1'b0, inA} + {1'b0, inB} + (W+1)'(cin);
        dif = {1'b0, inA} + {1'b0, ~inB} + (W+1)'(cin);
        s_r = '0;
        s_c = 1'b0;
        s_e = 1'b0;
        case (alu_cmd)
            CMD_W'(0): {s_c, s_r} = sum;
            CMD_W'(1): {s_c, s_r} = dif;
            CMD_W'(2): {s_c, s_r} = {inA, cin};
            CMD_W'(3): {s_r, s_c} = {inA[W-1], inA};
            CMD_W'(4): {s_r, s_c} = {cin, inA};
            CMD_W'(5): s_r = ~inA;
            CMD_W'(6): s_r = inA & inB;
            CMD_W'(7): s_r = inA ^ inB;
            CMD_W'(8): s_r = inA;
            CMD_W'(9): s_r = inA;
            default:   s_e = 1'b1;
        endcase
    end

    // final BUSY edge writes the last shift (or last partial product) straight into rslt
`ifdef ALU_MUL_EN
    assign prod_nxt = prod + (acc[0] ? mcand : '0);
    assign b_r = is_mul ? prod_nxt[W-1:0] : {acc[W-2:0], 1'b0};
    assign b_c = is_mul ? |prod_nxt[2*W-1:W] : acc[W-1];
`else
    assign b_r = {acc[W-2:0], 1'b0};
    assign b_c = acc[W-1];
`endif
    assign w_r = state == BUSY ? b_r : s_r;
    assign w_c = state == BUSY ? b_c : s_c;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            rslt      <= '0;
            sc_o      <= 1'b0;
            pari      <= 1'b0;
            zero      <= 1'b1;
            err       <= 1'b0;
`ifdef ALU_MUL_EN
            is_mul    <= 1'b0;
            mcand     <= '0;
            prod      <= '0;
`endif
        end else begin
            out_valid <= done;
            if (multi) begin
                acc <= mul ? inB : inA;
                cnt <= mul ? CW'(W) : CW'(n);
`ifdef ALU_MUL_EN
                is_mul <= mul;
                mcand  <= {{W{1'b0}}, inA};
                prod   <= '0;
`endif
            end else if (state == BUSY) begin
                cnt <= cnt - 1'b1;
`ifdef ALU_MUL_EN
                acc   <= is_mul ? acc >> 1 : acc << 1;
                mcand <= mcand << 1;
                prod  <= prod_nxt;
`else
                acc   <= acc << 1;
`endif
            end
            if (done) begin
                rslt <= w_r;
                sc_o <= w_c;
                pari <= ^w_r;
                zero <= w_r == '0;
                err  <= state == IDLE && s_e;
            end
        end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + random scoreboard bench for alu_seq (W=8).
// Expected results are queued at issue time and popped whenever out_valid is seen.
module tb_alu_seq;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sc_i = 1'b0, use_sc = 1'b0;
    logic [3:0] alu_cmd = '0;
    logic [7:0] inA = '0, inB = '0;
    logic in_ready, out_valid, sc_o, pari, zero, err;
    logic [7:0] rslt;
    int total = 0, bad = 0, run = 0, max_run = 0, busy_cnt = 0;
    logic m_sc = 1'b0;

    typedef struct {logic [7:0] r; logic c; logic e;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i), .use_sc(use_sc),
        .out_valid(out_valid), .rslt(rslt), .sc_o(sc_o), .pari(pari), .zero(zero), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // independent reference for single-cycle ops: returns {err, carry, result}
    function automatic logic [9:0] model(input logic [3:0] c, input logic [7:0] a, b, input logic ci);
        logic [8:0] t;
        logic e;
        e = 1'b0;
        case (c)
            4'd0: t = {1'b0, a} + {1'b0, b} + 9'(ci);
            4'd1: t = {1'b0, a} + {1'b0, ~b} + 9'(ci);
            4'd2: t = {a, ci};
            4'd3: t = {a[0], a[7], a[7:1]};
            4'd4: t = {a[0], ci, a[7:1]};
            4'd5: t = {1'b0, ~a};
            4'd6: t = {1'b0, a & b};
            4'd7: t = {1'b0, a ^ b};
            4'd8: t = {1'b0, a};
            default: begin t = '0; e = 1'b1; end
        endcase
        return {e, t};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        run = (rst_n && out_valid) ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (rst_n && out_valid) begin
            chk("result_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rslt", rslt, e.r);
                chk("sc_o", sc_o, e.c);
                chk("err", err, e.e);
                chk("pari", pari, ^e.r);
                chk("zero", zero, e.r == 8'h00);
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [7:0] a, b, input logic si, us,
                         input logic [7:0] er, input logic ec, ee, input logic push);
        int g = 0;
        while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
        chk("ready_wait", in_ready, 1);
        alu_cmd = c; inA = a; inB = b; sc_i = si; use_sc = us; in_valid = 1'b1;
        if (push) begin q.push_back('{er, ec, ee}); m_sc = ec; end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 100) begin @(negedge clk); g++; end
        chk("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] mv;
        logic [3:0] c;
        logic [7:0] a, b;
        logic si, us;
        #12;
        chk("rst_rslt", rslt, 0);
        chk("rst_zero", zero, 1);
        chk("rst_sc_o", sc_o, 0);
        chk("rst_pari", pari, 0);
        chk("rst_err", err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        // chained add
        issue(4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        issue(4'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        drain();
        // back-to-back single-cycle ops
        max_run = 0;
        issue(4'd1, 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1);
        issue(4'd3, 8'h81, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b1);
        issue(4'd5, 8'h0F, 8'h00, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("b2b_run", max_run, 3);
        issue(4'd2, 8'h81, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b1);
        issue(4'd4, 8'h81, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b1);
        issue(4'd6, 8'hA5, 8'h0F, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
        issue(4'd7, 8'hA5, 8'hFF, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        issue(4'd8, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        issue(4'd15, 8'h3C, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        drain();
        // SHLN with ignored in_valid pulses while busy
        issue(4'd9, 8'h03, 8'h03, 1'b0, 1'b0, 8'h18, 1'b0, 1'b0, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            alu_cmd = 4'd0; inA = 8'hFF; inB = 8'hFF; in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) busy_cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("shln_busy_cycles", busy_cnt, 3);
        chk("shln_ready_after", in_ready, 1);
        issue(4'd9, 8'h81, 8'h01, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1);
        issue(4'd9, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        drain();
`ifdef ALU_MUL_EN
        issue(4'd10, 8'h10, 8'h11, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 20 && !in_ready; i++) begin
            busy_cnt++;
            @(posedge clk); #1;
        end
        chk("mul_busy_cycles", busy_cnt, 8);
`else
        issue(4'd10, 8'h10, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
`endif
        drain();
        // reset in the middle of a long SHLN
        issue(4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();
        issue(4'd9, 8'h01, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_rslt", rslt, 0);
        chk("mid_rst_sc_o", sc_o, 0);
        chk("mid_rst_zero", zero, 1);
        m_sc = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(4'd0, 8'h10, 8'h20, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1);
        drain();
        // random single-cycle ops, back-to-back, with carry chaining
        for (int i = 0; i < 24; i++) begin
            c = 4'($urandom_range(0, 8));
            a = 8'($urandom);
            b = 8'($urandom);
            si = 1'($urandom);
            us = 1'($urandom);
            mv = model(c, a, b, us ? m_sc : si);
            issue(c, a, b, si, us, mv[7:0], mv[8], mv[9], 1'b1);
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
